// File: rtl/ctr_pr_n.sv
// Parametrised Fibonacci XOR LFSR counter with truncated modulus, up/down stepping,
// synchronous load and a combinational terminal-count flag.
`timescale 1ns/1ps
module ctr_pr_n #(
  parameter int unsigned W    = 4,
  parameter logic [W-1:0] TAPS = 4'b1100,
  parameter int unsigned SEED = 1,
  parameter int unsigned MOD  = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dir,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] out,
  output logic         tc
);

  localparam logic [W-1:0] SEED_V = SEED[W-1:0];
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};

  // Elaboration-time parameter sanity
  if (W < 32'd3 || W > 32'd24) begin : g_bad_w
    $error("ctr_pr_n: W must be in 3..24");
  end
  if (TAPS[W-1] != 1'b1) begin : g_bad_taps
    $error("ctr_pr_n: TAPS[W-1] must be 1");
  end
  if (SEED == 32'd0 || SEED >= (32'd1 << W)) begin : g_bad_seed
    $error("ctr_pr_n: SEED must be nonzero and below 2^W");
  end
  if (MOD < 32'd2 || MOD > ((32'd1 << W) - 32'd1)) begin : g_bad_mod
    $error("ctr_pr_n: MOD must be in 2..2^W-1");
  end

  function automatic logic [W-1:0] fwd_step(input logic [W-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
    return {s[W-2:0], fb};
  endfunction

  // Inverse of fwd_step: the bit shifted out is recovered from the feedback equation.
  function automatic logic [W-1:0] rev_step(input logic [W-1:0] s);
    logic [W-1:0] p;
    p[W-2:0] = s[W-1:1];
    p[W-1]   = s[0] ^ (^(s[W-1:1] & TAPS[W-2:0]));
    return p;
  endfunction

  function automatic logic [W-1:0] calc_term();
    logic [W-1:0] t;
    t = SEED_V;
    for (int unsigned i = 32'd1; i < MOD; i++) begin
      t = fwd_step(t);
    end
    return t;
  endfunction

  localparam logic [W-1:0] TERM = calc_term();

  logic [W-1:0] s_q;
  logic [W-1:0] s_d;
  logic         at_term;
  logic         at_seed;

  assign at_term = (s_q == TERM);
  assign at_seed = (s_q == SEED_V);
  assign out     = s_q;
  assign tc      = inc & ~ld & ((~dir & at_term) | (dir & at_seed));

  // Next-state selection: load beats stepping; wraps jump between SEED and TERM.
  always_comb begin
    s_d = s_q;
    if (ld) begin
      if (d == ZERO_V) begin
        s_d = SEED_V;
      end else begin
        s_d = d;
      end
    end else if (inc) begin
      if (dir) begin
        if (at_seed) begin
          s_d = TERM;
        end else begin
          s_d = rev_step(s_q);
        end
      end else begin
        if (at_term) begin
          s_d = SEED_V;
        end else begin
          s_d = fwd_step(s_q);
        end
      end
    end else begin
      s_d = s_q;
    end
  end

  // State register with asynchronous reset to SEED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= SEED_V;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: tb/tb_ctr_pr_n.sv
// Randomised and directed bench for ctr_pr_n: full (MOD=15) and truncated (MOD=6)
// instances share stimulus and are checked against a sequence-table reference.
`timescale 1ns/1ps
module tb_ctr_pr_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc;
  logic       dir;
  logic       ld;
  logic [3:0] d;
  logic [3:0] out_f;
  logic [3:0] out_t;
  logic       tc_f;
  logic       tc_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Maximal sequence for x^4+x^3+1 starting at 0001
  logic [3:0] seq [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                           4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
  logic [3:0] m_f;
  logic [3:0] m_t;

  ctr_pr_n #(.W(4), .TAPS(4'b1100), .SEED(1), .MOD(15)) u_full (
    .clk(clk), .rst(rst), .inc(inc), .dir(dir), .ld(ld), .d(d), .out(out_f), .tc(tc_f)
  );

  ctr_pr_n #(.W(4), .TAPS(4'b1100), .SEED(1), .MOD(6)) u_trunc (
    .clk(clk), .rst(rst), .inc(inc), .dir(dir), .ld(ld), .d(d), .out(out_t), .tc(tc_t)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 15; i++) begin
      if (seq[i] == v) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] ref_next(input logic [3:0] v, input int mod, input logic dn);
    int i;
    i = idx_of(v);
    if (i < 0) return v;
    if (!dn) return (v == seq[mod-1]) ? seq[0] : seq[(i + 1) % 15];
    return (v == seq[0]) ? seq[mod-1] : seq[(i + 14) % 15];
  endfunction

  function automatic logic [3:0] ref_tc(input logic [3:0] v, input int mod);
    logic t;
    t = inc && !ld && ((!dir && v == seq[mod-1]) || (dir && v == seq[0]));
    return {3'b000, t};
  endfunction

  task automatic ref_update();
    if (ld) begin
      m_f = (d == 4'd0) ? 4'd1 : d;
      m_t = (d == 4'd0) ? 4'd1 : d;
    end else if (inc) begin
      m_f = ref_next(m_f, 15, dir);
      m_t = ref_next(m_t, 6, dir);
    end
  endtask

  // One clock: apply inputs, check tc before the edge and out after it.
  task automatic cycle(input logic i_inc, input logic i_dir, input logic i_ld, input logic [3:0] i_d);
    inc = i_inc;
    dir = i_dir;
    ld  = i_ld;
    d   = i_d;
    #1;
    chk("tc_full", {3'b000, tc_f}, ref_tc(m_f, 15));
    chk("tc_trunc", {3'b000, tc_t}, ref_tc(m_t, 6));
    @(posedge clk);
    ref_update();
    #1;
    chk("out_full", out_f, m_f);
    chk("out_trunc", out_t, m_t);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    inc = 1'b0;
    dir = 1'b0;
    ld  = 1'b0;
    d   = 4'd0;
    m_f = 4'd1;
    m_t = 4'd1;
    #12;
    chk("reset_full", out_f, 4'd1);
    chk("reset_trunc", out_t, 4'd1);
    @(negedge clk);
    rst = 1'b0;

    // Full and truncated up-count, then a whole-period check
    repeat (15) cycle(1'b1, 1'b0, 1'b0, 4'd0);
    chk("full_period", out_f, 4'd1);
    chk("trunc_after15", out_t, 4'd9);

    // Down-count through the SEED->TERM wrap
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 4'd0);

    // Load wins over inc; zero load maps to SEED; hold
    cycle(1'b1, 1'b0, 1'b1, 4'd13);
    chk("ld_value", out_t, 4'd13);
    cycle(1'b1, 1'b1, 1'b1, 4'd0);
    chk("ld_zero", out_f, 4'd1);
    repeat (10) cycle(1'b0, 1'($urandom), 1'b0, 4'($urandom));

    // Out-of-cycle load in the truncated counter rejoins at SEED
    cycle(1'b0, 1'b0, 1'b1, 4'd13);
    repeat (14) cycle(1'b1, 1'b0, 1'b0, 4'd0);

    // Async reset between edges, held across two edges
    cycle(1'b0, 1'b0, 1'b1, 4'd6);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_trunc", out_t, 4'd1);
    chk("async_rst_full", out_f, 4'd1);
    m_f = 4'd1;
    m_t = 4'd1;
    inc = 1'b1;
    ld  = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold", out_t, 4'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 4'd0);

    // Random mix including direction toggles and occasional loads
    repeat (400) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) == 0),
            4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
